// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: row count, ShiftRows offsets,
// cipher direction and skid-buffer occupancy encoding.
package aes_pkg;

    localparam int AES_ROWS = 4;

    typedef enum logic {
        AES_ENC = 1'b0,
        AES_DEC = 1'b1
    } aes_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Rijndael uses a larger shift on rows 2 and 3 for 256-bit blocks.
    function automatic int aes_shift_offset(input int nb, input int row);
        if (nb == 8 && row >= 2)
            return row + 1;
        return row;
    endfunction

endpackage

// File: rtl/aes_shiftrow_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for a
// row-major Nb-column state; byte 0 of each row is its MSB byte.
module aes_shiftrow_perm
    import aes_pkg::*;
#(
    parameter  int NB = 4,
    localparam int W  = 32 * NB
) (
    input  logic         decrypt,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    for (genvar r = 0; r < AES_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S  = aes_shift_offset(NB, r);
            localparam int SE = (c + S) % NB;
            localparam int SD = (c + NB - S) % NB;
            localparam int HI = W - 1 - 8 * (r * NB + c);
            localparam int HE = W - 1 - 8 * (r * NB + SE);
            localparam int HD = W - 1 - 8 * (r * NB + SD);

            assign dout[HI -: 8] = decrypt ? din[HD -: 8]
                                           : din[HE -: 8];
        end
    end

endmodule

// File: rtl/aes_shiftrow_pipe.sv
// ShiftRows/InvShiftRows stage with valid/ready and a 2-entry skid buffer.
// Define AES_SHIFTROW_PERF_EN to add perf_blocks/perf_stalls counters.
module aes_shiftrow_pipe
    import aes_pkg::*;
#(
    parameter  int NB    = 4,
    parameter  int TAG_W = 4,
    localparam int W     = 32 * NB
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_decrypt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
`ifdef AES_SHIFTROW_PERF_EN
    output logic [31:0]      perf_blocks,
    output logic [31:0]      perf_stalls,
`endif
    output logic [TAG_W-1:0] out_tag
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shiftrow_pipe: NB must be 4, 6 or 8");
    end

    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_shiftrow_pipe: TAG_W must be at least 1");
    end

    aes_mode_e         mode;
    logic [W-1:0]      perm_data;

    skid_state_e       state;
    skid_state_e       state_nxt;
    logic              rdy_q;
    logic [W-1:0]      m_data;
    logic [TAG_W-1:0]  m_tag;
    logic [W-1:0]      s_data;
    logic [TAG_W-1:0]  s_tag;

    logic              accept;
    logic              xfer;
    logic              load_m;
    logic              load_s;
    logic              shift_s;

    assign mode = aes_mode_e'(in_decrypt);

    aes_shiftrow_perm #(
        .NB      (NB)
    ) u_perm (
        .decrypt (mode == AES_DEC),
        .din     (in_data),
        .dout    (perm_data)
    );

    assign in_ready  = rdy_q & ~reset;
    assign out_valid = (state != EMPTY);
    assign out_data  = m_data;
    assign out_tag   = m_tag;

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_m    = 1'b1;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    state_nxt = TWO;
                    load_s    = 1'b1;
                end else if (xfer && !accept) begin
                    state_nxt = EMPTY;
                end else if (xfer && accept) begin
                    load_m    = 1'b1;
                end
            end
            TWO: begin
                if (xfer) begin
                    state_nxt = ONE;
                    shift_s   = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready is a flop so upstream never sees a combinational path
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= EMPTY;
            rdy_q  <= 1'b1;
            m_data <= '0;
            m_tag  <= '0;
            s_data <= '0;
            s_tag  <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != TWO);
            if (load_m) begin
                m_data <= perm_data;
                m_tag  <= in_tag;
            end else if (shift_s) begin
                m_data <= s_data;
                m_tag  <= s_tag;
            end
            if (load_s) begin
                s_data <= perm_data;
                s_tag  <= in_tag;
            end
        end
    end

`ifdef AES_SHIFTROW_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_blocks <= '0;
            perf_stalls <= '0;
        end else begin
            if (xfer)
                perf_blocks <= perf_blocks + 32'd1;
            if (out_valid && !out_ready)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    // counters are not built in this configuration
`endif

endmodule

// File: tb/tb_aes_shiftrow_pipe.sv
// Directed bench for aes_shiftrow_pipe (NB=4 and NB=8 instances).
// Expected states are hand-computed constants.
module tb_aes_shiftrow_pipe;

    localparam logic [127:0] A     = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] ENC_A = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
    localparam logic [127:0] DEC_A = 128'h00010203_07040506_0A0B0809_0D0E0F0C;

    localparam logic [255:0] B8 =
        256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F;
    localparam logic [255:0] DEC_B8 =
        256'h0001020304050607_0F08090A0B0C0D0E_1516171011121314_1C1D1E1F18191A1B;
    localparam logic [255:0] ENC_B8 =
        256'h0001020304050607_090A0B0C0D0E0F08_1314151617101112_1C1D1E1F18191A1B;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_decrypt;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_tag;

    logic         in_valid8;
    logic         in_ready8;
    logic [255:0] in_data8;
    logic         in_decrypt8;
    logic [3:0]   in_tag8;
    logic         out_valid8;
    logic         out_ready8;
    logic [255:0] out_data8;
    logic [3:0]   out_tag8;

`ifdef AES_SHIFTROW_PERF_EN
    logic [31:0]  perf_blocks;
    logic [31:0]  perf_stalls;
    logic [31:0]  perf_blocks8;
    logic [31:0]  perf_stalls8;
`endif

    int total;
    int bad;

    aes_shiftrow_pipe #(.NB(4), .TAG_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_decrypt  (in_decrypt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
`ifdef AES_SHIFTROW_PERF_EN
        .perf_blocks (perf_blocks),
        .perf_stalls (perf_stalls),
`endif
        .out_tag     (out_tag)
    );

    aes_shiftrow_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .in_data     (in_data8),
        .in_decrypt  (in_decrypt8),
        .in_tag      (in_tag8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .out_data    (out_data8),
`ifdef AES_SHIFTROW_PERF_EN
        .perf_blocks (perf_blocks8),
        .perf_stalls (perf_stalls8),
`endif
        .out_tag     (out_tag8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        step();
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_data !== 128'h0) begin
            bad++;
            $display("FAIL rst_out_data got=%h want=0", out_data);
        end
        total++;
        if (out_tag !== 4'h0) begin
            bad++;
            $display("FAIL rst_out_tag got=%h want=0", out_tag);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready_low got=%b want=0", in_ready);
        end
        total++;
        if (out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid8 got=%b want=0", out_valid8);
        end
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready_high got=%b want=1", in_ready);
        end
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready8_high got=%b want=1", in_ready8);
        end
    endtask

    task automatic test_enc();
        apply_reset();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = A;
        in_decrypt = 1'b0;
        in_tag     = 4'h3;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL enc_latency got=%b want=1", out_valid);
        end
        total++;
        if (out_data !== ENC_A) begin
            bad++;
            $display("FAIL enc_data got=%h want=%h", out_data, ENC_A);
        end
        total++;
        if (out_tag !== 4'h3) begin
            bad++;
            $display("FAIL enc_tag got=%h want=3", out_tag);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL enc_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_dec();
        apply_reset();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = A;
        in_decrypt = 1'b1;
        in_tag     = 4'h5;
        step();
        total++;
        if (out_data !== DEC_A || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL dec_data got=%h/%b want=%h/1", out_data, out_valid, DEC_A);
        end
        total++;
        if (out_tag !== 4'h5) begin
            bad++;
            $display("FAIL dec_tag got=%h want=5", out_tag);
        end
        in_data = ENC_A;
        in_tag  = 4'h6;
        step();
        in_valid = 1'b0;
        total++;
        if (out_data !== A || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL roundtrip got=%h/%b want=%h/1", out_data, out_valid, A);
        end
        total++;
        if (out_tag !== 4'h6) begin
            bad++;
            $display("FAIL roundtrip_tag got=%h want=6", out_tag);
        end
    endtask

    task automatic test_nb8();
        apply_reset();
        out_ready8  = 1'b1;
        in_valid8   = 1'b1;
        in_data8    = B8;
        in_decrypt8 = 1'b1;
        in_tag8     = 4'h7;
        step();
        total++;
        if (out_data8 !== DEC_B8 || out_valid8 !== 1'b1) begin
            bad++;
            $display("FAIL nb8_dec got=%h want=%h", out_data8, DEC_B8);
        end
        total++;
        if (out_tag8 !== 4'h7) begin
            bad++;
            $display("FAIL nb8_dec_tag got=%h want=7", out_tag8);
        end
        in_decrypt8 = 1'b0;
        in_tag8     = 4'h2;
        step();
        in_valid8 = 1'b0;
        total++;
        if (out_data8 !== ENC_B8 || out_valid8 !== 1'b1) begin
            bad++;
            $display("FAIL nb8_enc got=%h want=%h", out_data8, ENC_B8);
        end
        total++;
        if (out_tag8 !== 4'h2) begin
            bad++;
            $display("FAIL nb8_enc_tag got=%h want=2", out_tag8);
        end
    endtask

    task automatic test_backpressure();
        int           nacc;
        int           nout;
        bit           fell;
        logic [127:0] held;
        logic [127:0] exp;
        nacc = 0;
        nout = 0;
        fell = 1'b0;
        held = '0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            out_ready           = !(i >= 1 && i <= 5);
            in_valid            = (nacc < 5);
            in_data             = A;
            in_data[127:120]    = 8'(nacc);
            in_decrypt          = 1'b0;
            in_tag              = 4'(nacc);
            if (!fell && !in_ready) begin
                fell = 1'b1;
                total++;
                if (nacc != 2) begin
                    bad++;
                    $display("FAIL bp_ready_fall accepts=%0d want=2", nacc);
                end
            end
            if (i == 1)
                held = out_data;
            if (i >= 2 && i <= 5) begin
                total++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                exp           = ENC_A;
                exp[127:120]  = 8'(nout);
                total++;
                if (out_tag !== 4'(nout) || out_data !== exp) begin
                    bad++;
                    $display("FAIL bp_order got=%h/%h want=%h/%h",
                             out_tag, out_data, 4'(nout), exp);
                end
                nout++;
            end
            if (in_valid && in_ready)
                nacc++;
            step();
        end
        in_valid = 1'b0;
        total++;
        if (!fell) begin
            bad++;
            $display("FAIL bp_ready_never_fell got=1 want=0");
        end
        total++;
        if (nout != 5 || nacc != 5) begin
            bad++;
            $display("FAIL bp_count out=%0d acc=%0d want=5/5", nout, nacc);
        end
`ifdef AES_SHIFTROW_PERF_EN
        total++;
        if (perf_stalls !== 32'd5) begin
            bad++;
            $display("FAIL perf_stalls got=%0d want=5", perf_stalls);
        end
        total++;
        if (perf_blocks !== 32'd5) begin
            bad++;
            $display("FAIL perf_blocks got=%0d want=5", perf_blocks);
        end
`endif
    endtask

    task automatic test_alternate();
        logic [127:0] exp;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid   = (i < 4);
            in_data    = A;
            in_decrypt = (i % 2 == 1);
            in_tag     = 4'(i);
            if (i >= 1 && i <= 4) begin
                exp = ((i - 1) % 2 == 1) ? DEC_A : ENC_A;
                total++;
                if (out_valid !== 1'b1 || out_data !== exp || out_tag !== 4'(i - 1)) begin
                    bad++;
                    $display("FAIL alt cyc=%0d got=%b/%h/%h want=1/%h/%h",
                             i, out_valid, out_data, out_tag, exp, 4'(i - 1));
                end
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL alt_ready cyc=%0d got=%b want=1", i, in_ready);
                end
            end
            if (i == 5) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL alt_drain got=%b want=0", out_valid);
                end
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_in_two();
        apply_reset();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = A;
        in_decrypt = 1'b0;
        in_tag     = 4'h1;
        step();
        in_tag = 4'h2;
        step();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL two_state got=%b/%b want=0/1", in_ready, out_valid);
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || out_tag !== 4'h0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h/%h want=0/0/0", out_valid, out_data, out_tag);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_ready got=%b want=0", in_ready);
        end
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready got=%b want=1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stale_block cyc=%0d got=%b want=0", i, out_valid);
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_decrypt  = 1'b0;
        in_tag      = '0;
        out_ready   = 1'b0;
        in_valid8   = 1'b0;
        in_data8    = '0;
        in_decrypt8 = 1'b0;
        in_tag8     = '0;
        out_ready8  = 1'b0;

        test_reset();
        test_enc();
        test_dec();
        test_nb8();
        test_backpressure();
        test_alternate();
        test_reset_in_two();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_shiftrow_pipe.md
Name: aes_shiftrow_pipe

Overview:
- Parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. Replaces the fixed-width, decrypt-only, free-running 128/256-bit blocks.
- Column count is selectable (Nb = 4, 6, 8). Encrypt or decrypt is chosen per transaction.
- Carries a sideband tag and uses valid/ready on both sides with a 2-entry skid buffer, so it can sit between round stages under backpressure.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; any other value is a $error at elaboration.
- TAG_W, 4, sideband tag width (round index or key-slot ID); at least 1.
- W, 32*NB, derived state width; not overridable.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream block valid.
- in_ready  out  1  stage can accept a block.
- in_data  in  W  input state.
- in_decrypt  in  1  1 = InvShiftRows, 0 = ShiftRows; sampled with the block.
- in_tag  in  TAG_W  sideband; passes through unchanged.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  shifted state.
- out_tag  out  TAG_W  tag of the block on out_data.

Behaviour:
- Clocking and reset: one clock (clock). Reset (reset) is synchronous and active-high.
- Layout: row-major. Row r (0..3) occupies bits [W-1-r*8*NB -: 8*NB]. Byte c (0..NB-1) of that row sits at offset 8*c from the row's MSB end, so byte 0 is the most significant.
- Shift offsets s_r:
  - NB=4 or 6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Encrypt: out[r][c] = in[r][(c + s_r) mod NB]. Decrypt: out[r][c] = in[r][(c - s_r) mod NB].
- The permutation is combinational on the input side and is registered on accept. Latency is exactly 1 cycle from the accept edge to out_valid.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - Transfer out when out_valid && out_ready.
  - in_data, in_decrypt and in_tag must be stable only in the accept cycle.
  - out_data and out_tag must not change while out_valid=1 and out_ready=0.
- Buffering uses a main register (M) and a skid register (S).
- States:
  - EMPTY: M and S empty.
  - ONE: M full.
  - TWO: M and S full.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept and no transfer -> TWO (the new block goes to S).
  - ONE + transfer and no accept -> EMPTY.
  - ONE + both -> ONE (M is reloaded).
  - TWO + transfer -> ONE (S moves to M).
- Readiness:
  - in_ready = !S_valid, registered; it is deasserted only in TWO.
  - out_valid = M_valid.
- Throughput is 1 block/cycle with out_ready held high. Order is strictly FIFO and the mode never reorders blocks.
- Reset:
  - out_valid=0, out_data=0, out_tag=0; state -> EMPTY.
  - in_ready=0 while reset=1, and 1 on the first cycle after reset deasserts.
  - Reset mid-operation discards both entries with no output pulse.
- Simultaneous accept and transfer in ONE performs no bubble and no duplication.

Optional Feature:
- Macro: AES_SHIFTROW_PERF_EN.
- When defined, two extra output ports are added:
  - perf_blocks (32 bits): counts transfers.
  - perf_stalls (32 bits): counts cycles with out_valid && !out_ready.
- Both counters wrap modulo 2^32 and are cleared by reset.
- When undefined, the ports and counters are absent and the remaining behaviour is unchanged.

Decomposition:
- Package aes_pkg holds:
  - localparam AES_ROWS=4.
  - Function aes_shift_offset(nb, row).
  - typedef aes_mode_e {AES_ENC=0, AES_DEC=1}.
  - typedef skid_state_e {EMPTY, ONE, TWO}.
- Sub-module aes_shiftrow_perm: purely combinational (NB, decrypt, data -> data). It is reused by the round-unrolled core and makes the bench's reference model trivial.

Test Plan:
- NB=4, enc, in_data=00010203_04050607_08090A0B_0C0D0E0F, out_ready=1 -> 1 cycle later out_data=00010203_05060704_0A0B0809_0F0C0D0E.
- NB=4, dec, same input -> out_data=00010203_07040506_0A0B0809_0D0E0F0C. Feeding enc output back with dec returns the original.
- NB=8, dec, row2 bytes 10..17 -> row2 out 15 16 17 10 11 12 13 14; row3 bytes 18..1F -> 1C 1D 1E 1F 18 19 1A 1B.
- Backpressure: stream 5 blocks (tags 0..4) with out_ready=0 for cycles 2..6:
  - in_ready falls after 2 accepts.
  - out_data stays stable while stalled.
  - After release, tags leave in order 0..4 with no loss or duplicate.
  - With the perf macro: perf_stalls=5, perf_blocks=5.
- Alternating enc/dec every cycle at full rate -> each output matches its own mode; zero bubbles.
- Reset asserted while in TWO -> next cycle out_valid=0, out_data=0; in_ready=1 after deassert; no stale block appears.
